// File: rtl/nes_joypad_port.sv
// NES controller-port serializer: per-player autofire, strobe-latched shift
// registers for $4016/$4017, optional Four Score multiplexing with signatures.

module nes_af_btn #(
  parameter int AF_HALF = 715_900,
  parameter int AF_W    = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic phase
);
  localparam logic [AF_W-1:0] LAST = AF_W'(AF_HALF - 1);

  logic [AF_W-1:0] cnt;
  logic            held;

  // First held cycle only arms the phase; counting starts on the following one
  // so that each phase lasts exactly AF_HALF cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      held  <= 1'b0;
      phase <= 1'b0;
    end else if (!btn) begin
      cnt   <= '0;
      held  <= 1'b0;
      phase <= 1'b0;
    end else if (!held) begin
      held  <= 1'b1;
      phase <= 1'b1;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end
endmodule

module nes_af_lane #(
  parameter int BTN_W    = 12,
  parameter int AF_HALF  = 715_900,
  parameter int AF_A_BIT = 8,
  parameter int AF_B_BIT = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] joy,
  output logic [7:0]       nes,
  output logic             active
);
  localparam int AF_W = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

  logic phase_a, phase_b;
  logic unused_bits;

  nes_af_btn #(.AF_HALF(AF_HALF), .AF_W(AF_W)) u_af_a (
    .clk(clk), .reset(reset), .btn(joy[AF_A_BIT]), .phase(phase_a)
  );
  nes_af_btn #(.AF_HALF(AF_HALF), .AF_W(AF_W)) u_af_b (
    .clk(clk), .reset(reset), .btn(joy[AF_B_BIT]), .phase(phase_b)
  );

  assign nes         = {joy[7:2], joy[1] | phase_b, joy[0] | phase_a};
  assign active      = phase_a | phase_b;
  assign unused_bits = ^joy;
endmodule

module nes_joypad_port #(
  parameter int NUM_PLAYERS = 2,
  parameter int BTN_W       = 12,
  parameter int AF_HALF     = 715_900,
  parameter int AF_A_BIT    = 8,
  parameter int AF_B_BIT    = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PLAYERS*BTN_W-1:0] joy,
  input  logic                         fourscore_en,
  input  logic                         joypad_strobe,
  input  logic [1:0]                   joypad_clock,
  output logic                         joypad1_data,
  output logic                         joypad2_data,
  output logic [NUM_PLAYERS-1:0]       af_active
);
  localparam bit FS_OK = (NUM_PLAYERS == 4);

  logic [NUM_PLAYERS-1:0][7:0] nes;
  logic [7:0]  nes2, nes3;
  logic [23:0] sr1, sr2;
  logic [1:0]  last_clk, fall;
  logic        fs;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
    nes_af_lane #(
      .BTN_W(BTN_W), .AF_HALF(AF_HALF), .AF_A_BIT(AF_A_BIT), .AF_B_BIT(AF_B_BIT)
    ) u_lane (
      .clk(clk), .reset(reset), .joy(joy[p*BTN_W +: BTN_W]),
      .nes(nes[p]), .active(af_active[p])
    );
  end

  if (FS_OK) begin : g_fs
    assign nes2 = nes[2];
    assign nes3 = nes[3];
  end else begin : g_nofs
    assign nes2 = 8'h00;
    assign nes3 = 8'h00;
  end

  assign fs   = fourscore_en & FS_OK;
  assign fall = last_clk & ~joypad_clock;

  // Strobe is a level-sensitive parallel load and overrides any coincident shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr1      <= 24'h0;
      sr2      <= 24'h0;
      last_clk <= 2'b00;
    end else begin
      last_clk <= joypad_clock;
      if (joypad_strobe) begin
        sr1 <= fs ? {8'h10, nes2, nes[0]} : {16'hFFFF, nes[0]};
        sr2 <= fs ? {8'h20, nes3, nes[1]} : {16'hFFFF, nes[1]};
      end else begin
        if (fall[0]) sr1 <= {1'b1, sr1[23:1]};
        if (fall[1]) sr2 <= {1'b1, sr2[23:1]};
      end
    end
  end

  assign joypad1_data = sr1[0];
  assign joypad2_data = sr2[0];
endmodule
